reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 12 +
 rtl/reg_bank_if.sv | 31 +++
 rtl/reg_bank_read_port.sv | 46 ++++
 rtl/reg_bank.sv | 87 ++++++++
 tb/tb_reg_bank.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the register bank and the datapath blocks built around it.
package reg_bank_pkg;

   localparam int REG_WIDTH  = 8;
   localparam int REG_ADDR_W = 2;

   // Number of registers addressed by an addr_w-bit address.
   function automatic int depth(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Register bank access bus: one write port, two read ports sharing a read enable, clear, status.
interface reg_bank_if
   import reg_bank_pkg::*;
#(
   parameter int WIDTH  = REG_WIDTH,
   parameter int ADDR_W = REG_ADDR_W
);
   localparam int DEPTH = depth(ADDR_W);

   logic              WE;
   logic [ADDR_W-1:0] DIR_WR;
   logic [WIDTH-1:0]  DI;
   logic              RE;
   logic [ADDR_W-1:0] DIR_A;
   logic [ADDR_W-1:0] DIR_B;
   logic              CLR;
   logic [WIDTH-1:0]  DOA;
   logic [WIDTH-1:0]  DOB;
   logic              DVALID;
   logic [DEPTH-1:0]  DIRTY;

   modport master (
      output WE, DIR_WR, DI, RE, DIR_A, DIR_B, CLR,
      input  DOA, DOB, DVALID, DIRTY
   );

   modport slave (
      input  WE, DIR_WR, DI, RE, DIR_A, DIR_B, CLR,
      output DOA, DOB, DVALID, DIRTY
   );
endinterface

// File: rtl/reg_bank_read_port.sv
// Single registered read port: address mux, same-cycle write bypass, optional hard-wired zero register.
module rb_read_port
   import reg_bank_pkg::*;
#(
   parameter int WIDTH    = REG_WIDTH,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter bit ZERO_REG = 1'b0,
   localparam int DEPTH   = depth(ADDR_W)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         re_i,
   input  logic [ADDR_W-1:0]            addr_i,
   input  logic [DEPTH-1:0][WIDTH-1:0]  regs_i,
   input  logic                         wr_en_i,    // write that will really commit this edge
   input  logic [ADDR_W-1:0]            wr_addr_i,
   input  logic [WIDTH-1:0]             wr_data_i,
   output logic [WIDTH-1:0]             dout_o
);

   logic [WIDTH-1:0] dout_d;
   logic [WIDTH-1:0] dout_q;

   // Select read data: zero register first, then bypass of the committing write, else stored value.
   always_comb begin
      dout_d = regs_i[addr_i];
      if (ZERO_REG && (addr_i == '0)) begin
         dout_d = '0;
      end else if (wr_en_i && (wr_addr_i == addr_i)) begin
         dout_d = wr_data_i;
      end
   end

   // Output register: loads only on a read, otherwise holds the last read value.
   always_ff @(posedge clk) begin
      // NOTE: state is assigned with <= so every flop samples pre-edge values, regardless of block order.
      if (rst) begin
         dout_q <= '0;
      end else if (re_i) begin
         dout_q <= dout_d;
      end
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/reg_bank.sv
// Flip-flop register bank with one write port, two registered read ports, bulk clear and dirty flags.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int WIDTH    = REG_WIDTH,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   reg_bank_if.slave  rb
);

   localparam int DEPTH = depth(ADDR_W);

   logic [DEPTH-1:0][WIDTH-1:0] regs_d, regs_q;
   logic [DEPTH-1:0]            dirty_d, dirty_q;
   logic                        dvalid_q;
   logic                        wr_en;

   // A write commits only when clear is idle and it does not target a hard-wired zero register.
   assign wr_en = rb.WE && !rb.CLR && !(ZERO_REG && (rb.DIR_WR == '0));

   // Next storage and dirty state: clear beats write.
   always_comb begin
      // NOTE: defaults first so every path assigns every bit and no latch is inferred.
      regs_d  = regs_q;
      dirty_d = dirty_q;
      if (rb.CLR) begin
         regs_d  = '0;
         dirty_d = '0;
      end else if (wr_en) begin
         regs_d[rb.DIR_WR]  = rb.DI;
         dirty_d[rb.DIR_WR] = 1'b1;
      end
   end

   // Storage, dirty and read-valid registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the array is flops, not RAM, and must read zero after reset, so it is reset explicitly.
         regs_q   <= '0;
         dirty_q  <= '0;
         dvalid_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         dirty_q  <= dirty_d;
         dvalid_q <= rb.RE;
      end
   end

   rb_read_port #(
      .WIDTH    (WIDTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_port_a (
      .clk       (clk),
      .rst       (rst),
      .re_i      (rb.RE),
      .addr_i    (rb.DIR_A),
      .regs_i    (regs_q),
      .wr_en_i   (wr_en),
      .wr_addr_i (rb.DIR_WR),
      .wr_data_i (rb.DI),
      .dout_o    (rb.DOA)
   );

   rb_read_port #(
      .WIDTH    (WIDTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_port_b (
      .clk       (clk),
      .rst       (rst),
      .re_i      (rb.RE),
      .addr_i    (rb.DIR_B),
      .regs_i    (regs_q),
      .wr_en_i   (wr_en),
      .wr_addr_i (rb.DIR_WR),
      .wr_data_i (rb.DI),
      .dout_o    (rb.DOB)
   );

   assign rb.DVALID = dvalid_q;
   assign rb.DIRTY  = dirty_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: vector table on the default bank, hand sequences for
// the zero-register variant and the 16-bit / 8-register variant.
module tb_reg_bank;

   logic clk;
   logic rst0, rst1, rst2;
   int   passed;
   int   total;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   reg_bank_if #(.WIDTH(8),  .ADDR_W(2)) bus0 ();
   reg_bank_if #(.WIDTH(8),  .ADDR_W(2)) bus1 ();
   reg_bank_if #(.WIDTH(16), .ADDR_W(3)) bus2 ();

   reg_bank #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(1'b0)) dut0 (.clk(clk), .rst(rst0), .rb(bus0.slave));
   reg_bank #(.WIDTH(8), .ADDR_W(2), .ZERO_REG(1'b1)) dut1 (.clk(clk), .rst(rst1), .rb(bus1.slave));
   reg_bank #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut2 (.clk(clk), .rst(rst2), .rb(bus2.slave));

   typedef struct packed {
      logic       rst;
      logic       we;
      logic [1:0] wr;
      logic [7:0] di;
      logic       re;
      logic [1:0] a;
      logic [1:0] b;
      logic       clr;
      logic [7:0] doa;
      logic [7:0] dob;
      logic       dv;
      logic [3:0] dirty;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   function automatic vec_t mk(input logic r, input logic we, input logic [1:0] wr,
                               input logic [7:0] di, input logic re, input logic [1:0] a,
                               input logic [1:0] b, input logic clr, input logic [7:0] doa,
                               input logic [7:0] dob, input logic dv, input logic [3:0] dirty);
      vec_t v;
      v.rst = r;  v.we = we;  v.wr = wr;  v.di = di;  v.re = re;  v.a = a;  v.b = b;
      v.clr = clr;  v.doa = doa;  v.dob = dob;  v.dv = dv;  v.dirty = dirty;
      return v;
   endfunction

   task automatic drv1(input logic r, input logic we, input logic [1:0] wr, input logic [7:0] di,
                       input logic re, input logic [1:0] a, input logic [1:0] b, input logic clr);
      rst1 = r;  bus1.WE = we;  bus1.DIR_WR = wr;  bus1.DI = di;
      bus1.RE = re;  bus1.DIR_A = a;  bus1.DIR_B = b;  bus1.CLR = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic drv2(input logic r, input logic we, input logic [2:0] wr, input logic [15:0] di,
                       input logic re, input logic [2:0] a, input logic [2:0] b);
      rst2 = r;  bus2.WE = we;  bus2.DIR_WR = wr;  bus2.DI = di;
      bus2.RE = re;  bus2.DIR_A = a;  bus2.DIR_B = b;  bus2.CLR = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst0 = 1'b1;  rst1 = 1'b1;  rst2 = 1'b1;
      bus0.WE = 0; bus0.DIR_WR = 0; bus0.DI = 0; bus0.RE = 0; bus0.DIR_A = 0; bus0.DIR_B = 0; bus0.CLR = 0;
      bus1.WE = 0; bus1.DIR_WR = 0; bus1.DI = 0; bus1.RE = 0; bus1.DIR_A = 0; bus1.DIR_B = 0; bus1.CLR = 0;
      bus2.WE = 0; bus2.DIR_WR = 0; bus2.DI = 0; bus2.RE = 0; bus2.DIR_A = 0; bus2.DIR_B = 0; bus2.CLR = 0;

      //              rst we wr di     re a  b  clr  doa    dob    dv dirty
      vecs[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 4'b0000); // reset
      vecs[1]  = mk(0, 0, 0, 8'h00, 1, 3, 1, 0, 8'h00, 8'h00, 1, 4'b0000); // read after reset
      vecs[2]  = mk(0, 1, 2, 8'hA5, 0, 0, 0, 0, 8'h00, 8'h00, 0, 4'b0100); // write reg2
      vecs[3]  = mk(0, 0, 0, 8'h00, 1, 2, 2, 0, 8'hA5, 8'hA5, 1, 4'b0100); // read reg2
      vecs[4]  = mk(0, 1, 1, 8'h11, 0, 0, 0, 0, 8'hA5, 8'hA5, 0, 4'b0110); // write reg1, outputs hold
      vecs[5]  = mk(0, 1, 1, 8'h7E, 1, 1, 0, 0, 8'h7E, 8'h00, 1, 4'b0110); // bypass on A only
      vecs[6]  = mk(0, 0, 0, 8'h00, 1, 1, 2, 0, 8'h7E, 8'hA5, 1, 4'b0110); // re-read reg1
      vecs[7]  = mk(0, 1, 0, 8'h01, 0, 0, 0, 0, 8'h7E, 8'hA5, 0, 4'b0111);
      vecs[8]  = mk(0, 1, 1, 8'h02, 0, 0, 0, 0, 8'h7E, 8'hA5, 0, 4'b0111);
      vecs[9]  = mk(0, 1, 2, 8'h03, 0, 0, 0, 0, 8'h7E, 8'hA5, 0, 4'b0111);
      vecs[10] = mk(0, 1, 3, 8'h04, 0, 0, 0, 0, 8'h7E, 8'hA5, 0, 4'b1111);
      vecs[11] = mk(0, 1, 3, 8'hFF, 1, 3, 0, 1, 8'h04, 8'h01, 1, 4'b0000); // clear wins, pre-clear read
      vecs[12] = mk(0, 0, 0, 8'h00, 1, 3, 1, 0, 8'h00, 8'h00, 1, 4'b0000); // cleared contents
      vecs[13] = mk(0, 1, 3, 8'hC3, 1, 3, 3, 0, 8'hC3, 8'hC3, 1, 4'b1000); // bypass on both ports
      vecs[14] = mk(1, 1, 0, 8'h99, 1, 3, 3, 0, 8'h00, 8'h00, 0, 4'b0000); // reset overrides access
      vecs[15] = mk(0, 0, 0, 8'h00, 1, 0, 3, 0, 8'h00, 8'h00, 1, 4'b0000); // write under reset discarded

      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         rst0 = vecs[i].rst;  bus0.WE = vecs[i].we;  bus0.DIR_WR = vecs[i].wr;  bus0.DI = vecs[i].di;
         bus0.RE = vecs[i].re;  bus0.DIR_A = vecs[i].a;  bus0.DIR_B = vecs[i].b;  bus0.CLR = vecs[i].clr;
         @(posedge clk);
         #1;
         check($sformatf("v%0d DOA", i),    64'(bus0.DOA),    64'(vecs[i].doa));
         check($sformatf("v%0d DOB", i),    64'(bus0.DOB),    64'(vecs[i].dob));
         check($sformatf("v%0d DVALID", i), 64'(bus0.DVALID), 64'(vecs[i].dv));
         check($sformatf("v%0d DIRTY", i),  64'(bus0.DIRTY),  64'(vecs[i].dirty));
      end

      // Zero register: writes to address 0 vanish, reads of 0 return 0, other addresses still bypass.
      drv1(1, 0, 0, 8'h00, 0, 0, 0, 0);
      drv1(0, 1, 0, 8'h5A, 1, 0, 0, 0);
      check("zr DOA write+read r0", 64'(bus1.DOA),   64'h00);
      check("zr DIRTY after r0 wr", 64'(bus1.DIRTY), 64'h0);
      drv1(0, 1, 1, 8'h33, 1, 1, 0, 0);
      check("zr DOA bypass r1",     64'(bus1.DOA),   64'h33);
      check("zr DOB r0",            64'(bus1.DOB),   64'h00);
      check("zr DIRTY r1",          64'(bus1.DIRTY), 64'b0010);
      drv1(0, 0, 0, 8'h00, 1, 0, 1, 0);
      check("zr DOA later r0",      64'(bus1.DOA),   64'h00);
      check("zr DOB r1 stored",     64'(bus1.DOB),   64'h33);
      drv1(0, 0, 0, 8'h00, 0, 0, 0, 0);

      // Wide bank: hold behaviour and reset with a pending write.
      drv2(1, 0, 0, 16'h0000, 0, 0, 0);
      drv2(0, 1, 5, 16'hBEEF, 0, 0, 0);
      check("w16 DIRTY reg5",       64'(bus2.DIRTY),  64'h20);
      drv2(0, 0, 0, 16'h0000, 1, 5, 5);
      check("w16 DOA read",         64'(bus2.DOA),    64'hBEEF);
      check("w16 DVALID read",      64'(bus2.DVALID), 64'h1);
      for (int k = 0; k < 3; k++) begin
         drv2(0, 0, 0, 16'h0000, 0, 2, 3);
         check($sformatf("w16 hold%0d DOA", k),    64'(bus2.DOA),    64'hBEEF);
         check($sformatf("w16 hold%0d DVALID", k), 64'(bus2.DVALID), 64'h0);
      end
      drv2(1, 1, 5, 16'h1234, 1, 5, 5);
      check("w16 rst DOA",          64'(bus2.DOA),    64'h0);
      check("w16 rst DOB",          64'(bus2.DOB),    64'h0);
      check("w16 rst DVALID",       64'(bus2.DVALID), 64'h0);
      check("w16 rst DIRTY",        64'(bus2.DIRTY),  64'h0);
      drv2(0, 0, 0, 16'h0000, 1, 5, 0);
      check("w16 reg5 after rst",   64'(bus2.DOA),    64'h0);
      check("w16 DVALID after rst", 64'(bus2.DVALID), 64'h1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
